// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types, constants and counter update for the fetch-stage branch predictor.
package bpu_pkg;
    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        ctr_e        ctr;
    } btb_entry_t;
    localparam logic [31:0] PC_INC = 32'd4;
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        return taken ? (c == ST ? ST : ctr_e'(c + 2'd1)) : (c == SNT ? SNT : ctr_e'(c - 2'd1));
    endfunction
endpackage

// File: rtl/btb_table.sv
// btb_table: direct-mapped branch target buffer with one combinational read port and one allocate/train write port.
//   clk_i, rst_i               clock, synchronous active-high reset (all entries invalid, counters WNT)
//   rd_pc_i -> rd_taken_o/rd_target_o   lookup; taken means hit with counter WT or ST
//   wr_en_i, wr_pc_i, wr_taken_i, wr_target_i   resolved branch training
module btb_table
    import bpu_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] rd_pc_i,
    output logic        rd_taken_o,
    output logic [31:0] rd_target_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_pc_i,
    input  logic        wr_taken_i,
    input  logic [31:0] wr_target_i
);
    localparam int IDX_W = $clog2(ENTRIES);
    btb_entry_t mem_q [ENTRIES];
    btb_entry_t rd_e, wr_e, entry_d;
    logic [IDX_W-1:0] ridx, widx;
    logic [29:0] rtag, wtag;
    logic wr_hit;
    // Tags keep the PC bits above the index, zero-extended to a fixed width.
    assign ridx = IDX_W'(rd_pc_i >> 2);
    assign widx = IDX_W'(wr_pc_i >> 2);
    assign rtag = 30'(rd_pc_i >> (IDX_W + 2));
    assign wtag = 30'(wr_pc_i >> (IDX_W + 2));
    assign rd_e = mem_q[ridx];
    assign wr_e = mem_q[widx];
    assign rd_taken_o  = rd_e.valid && rd_e.tag == rtag && rd_e.ctr inside {WT, ST};
    assign rd_target_o = rd_e.target;
    assign wr_hit = wr_e.valid && wr_e.tag == wtag;
    always_comb begin
        entry_d.valid  = 1'b1;
        entry_d.tag    = wtag;
        entry_d.target = (!wr_hit || wr_taken_i) ? wr_target_i : wr_e.target;
        entry_d.ctr    = wr_hit ? ctr_next(wr_e.ctr, wr_taken_i) : (wr_taken_i ? WT : WNT);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
        end else if (wr_en_i) begin
            mem_q[widx] <= entry_d;
        end
    end
endmodule

// File: rtl/fetch_bpu.sv
// fetch_bpu: instruction-fetch PC register with BTB-based next-PC prediction, mispredict redirect and perf counters.
//   clk_i, rst_i, stall_i            clock, synchronous active-high reset, PC hold request
//   ex_*                             branch resolution / redirect from EX
//   pc_o, pred_taken_o, pred_target_o  fetch address and its prediction
//   flush_o                          kill IF/ID and ID/EX on a redirect
//   perf_branch_o, perf_mispred_o    resolved-branch and mispredict counts
module fetch_bpu
    import bpu_pkg::*;
#(
    parameter int          BTB_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_branch_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_mispredict_i,
    input  logic [31:0] ex_redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    output logic        flush_o,
    output logic [31:0] perf_branch_o,
    output logic [31:0] perf_mispred_o
);
    logic [31:0] pc_q, pc_d, btb_target, perf_branch_q, perf_mispred_q;
    logic redirect, resolve;
    btb_table #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_pc_i    (pc_q),
        .rd_taken_o (pred_taken_o),
        .rd_target_o(btb_target),
        .wr_en_i    (resolve),
        .wr_pc_i    (ex_pc_i),
        .wr_taken_i (ex_taken_i),
        .wr_target_i(ex_target_i)
    );
    assign resolve       = ex_valid_i && ex_is_branch_i;
    assign redirect      = ex_valid_i && ex_mispredict_i;
    assign flush_o       = redirect && !rst_i;
    assign pred_target_o = pred_taken_o ? btb_target : pc_q + PC_INC;
    assign pc_d          = redirect ? ex_redirect_pc_i & ~32'h3 : stall_i ? pc_q : pred_target_o;
    assign pc_o           = pc_q;
    assign perf_branch_o  = perf_branch_q;
    assign perf_mispred_o = perf_mispred_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q           <= RESET_PC;
            perf_branch_q  <= '0;
            perf_mispred_q <= '0;
        end else begin
            pc_q           <= pc_d;
            perf_branch_q  <= perf_branch_q + 32'(resolve);
            perf_mispred_q <= perf_mispred_q + 32'(redirect);
        end
    end
endmodule

// File: tb/tb_fetch_bpu.sv
// tb_fetch_bpu: directed self-checking bench for fetch_bpu.
module tb_fetch_bpu;
    localparam logic [31:0] RPC = 32'h100;
    logic clk_i = 1'b0;
    logic rst_i, stall_i, ex_valid_i, ex_is_branch_i, ex_taken_i, ex_mispredict_i;
    logic [31:0] ex_pc_i, ex_target_i, ex_redirect_pc_i;
    logic [31:0] pc_o, pred_target_o, perf_branch_o, perf_mispred_o;
    logic pred_taken_o, flush_o;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_br = 0;
    logic [31:0] exp_mp = 0;

    always #5 clk_i = ~clk_i;

    fetch_bpu #(.BTB_ENTRIES(64), .RESET_PC(RPC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .ex_valid_i(ex_valid_i), .ex_is_branch_i(ex_is_branch_i), .ex_pc_i(ex_pc_i),
        .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i), .ex_mispredict_i(ex_mispredict_i),
        .ex_redirect_pc_i(ex_redirect_pc_i), .pc_o(pc_o), .pred_taken_o(pred_taken_o),
        .pred_target_o(pred_target_o), .flush_o(flush_o),
        .perf_branch_o(perf_branch_o), .perf_mispred_o(perf_mispred_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
        ex_valid_i = 0; ex_is_branch_i = 0; ex_taken_i = 0; ex_mispredict_i = 0;
    endtask

    task automatic drive_ex(input logic br, input logic tk, input logic mp,
                            input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] rpc);
        ex_valid_i = 1; ex_is_branch_i = br; ex_taken_i = tk; ex_mispredict_i = mp;
        ex_pc_i = pc; ex_target_i = tgt; ex_redirect_pc_i = rpc;
        if (br) exp_br += 1;
        if (mp) exp_mp += 1;
    endtask

    task automatic test_reset;
        rst_i = 1; stall_i = 0; ex_pc_i = 0; ex_target_i = 0; ex_redirect_pc_i = 0;
        tick; tick;
        rst_i = 0;
        n_cmp++; if (pc_o !== RPC) begin n_bad++; $display("FAIL rst_pc got=%h exp=%h", pc_o, RPC); end
        n_cmp++; if (pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL rst_pred_taken got=%b exp=0", pred_taken_o); end
        n_cmp++; if (pred_target_o !== 32'h104) begin n_bad++; $display("FAIL rst_pred_target got=%h exp=104", pred_target_o); end
        n_cmp++; if (perf_branch_o !== 0 || perf_mispred_o !== 0) begin n_bad++; $display("FAIL rst_perf got=%0d/%0d exp=0/0", perf_branch_o, perf_mispred_o); end
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL rst_flush got=%b exp=0", flush_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h104) begin n_bad++; $display("FAIL run_104 got=%h exp=104", pc_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h108 || pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL run_108 got=%h/%b exp=108/0", pc_o, pred_taken_o); end
    endtask

    task automatic test_taken_redirect;
        drive_ex(1, 1, 1, 32'h108, 32'h200, 32'h200);
        #1;
        n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL redir_flush got=%b exp=1", flush_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h200) begin n_bad++; $display("FAIL redir_pc got=%h exp=200", pc_o); end
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h108);
        tick;
        n_cmp++; if (pc_o !== 32'h108 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin n_bad++; $display("FAIL btb_hit got=%h/%b/%h exp=108/1/200", pc_o, pred_taken_o, pred_target_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h200) begin n_bad++; $display("FAIL pred_follow got=%h exp=200", pc_o); end
        n_cmp++; if (perf_branch_o !== exp_br || perf_mispred_o !== exp_mp) begin n_bad++; $display("FAIL perf_a got=%0d/%0d exp=%0d/%0d", perf_branch_o, perf_mispred_o, exp_br, exp_mp); end
    endtask

    task automatic test_ignored_mispredict;
        ex_valid_i = 0; ex_mispredict_i = 1; ex_redirect_pc_i = 32'h300;
        #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL ign_flush got=%b exp=0", flush_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h204 || perf_mispred_o !== exp_mp) begin n_bad++; $display("FAIL ign_pc got=%h/%0d exp=204/%0d", pc_o, perf_mispred_o, exp_mp); end
    endtask

    task automatic test_counter;
        drive_ex(1, 0, 0, 32'h108, 32'h0, 32'h0); tick;
        drive_ex(1, 0, 0, 32'h108, 32'h0, 32'h0); tick;
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h108); tick;
        n_cmp++; if (pc_o !== 32'h108 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h10C) begin n_bad++; $display("FAIL snt_pred got=%h/%b/%h exp=108/0/10c", pc_o, pred_taken_o, pred_target_o); end
        drive_ex(1, 0, 0, 32'h108, 32'h0, 32'h0); tick;
        drive_ex(1, 1, 0, 32'h108, 32'h200, 32'h0); tick;
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h108); tick;
        n_cmp++; if (pc_o !== 32'h108 || pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL sat_low got=%h/%b exp=108/0", pc_o, pred_taken_o); end
        drive_ex(1, 1, 0, 32'h108, 32'h200, 32'h0);
        #1;
        n_cmp++; if (pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL same_cycle got=%b exp=0", pred_taken_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h10C) begin n_bad++; $display("FAIL same_cycle_pc got=%h exp=10c", pc_o); end
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h108); tick;
        n_cmp++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin n_bad++; $display("FAIL wt_pred got=%b/%h exp=1/200", pred_taken_o, pred_target_o); end
    endtask

    task automatic test_alias;
        drive_ex(1, 1, 0, 32'h208, 32'h400, 32'h0); tick;
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h108); tick;
        n_cmp++; if (pc_o !== 32'h108 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h10C) begin n_bad++; $display("FAIL alias_miss got=%h/%b/%h exp=108/0/10c", pc_o, pred_taken_o, pred_target_o); end
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h208); tick;
        n_cmp++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h400) begin n_bad++; $display("FAIL alias_new got=%b/%h exp=1/400", pred_taken_o, pred_target_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h400) begin n_bad++; $display("FAIL alias_follow got=%h exp=400", pc_o); end
    endtask

    task automatic test_stall_redirect;
        stall_i = 1;
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h300); tick;
        n_cmp++; if (pc_o !== 32'h300) begin n_bad++; $display("FAIL stall_redir got=%h exp=300", pc_o); end
        tick; tick;
        n_cmp++; if (pc_o !== 32'h300) begin n_bad++; $display("FAIL stall_hold got=%h exp=300", pc_o); end
        drive_ex(1, 1, 0, 32'h300, 32'h500, 32'h0); tick;
        stall_i = 0;
        #1;
        n_cmp++; if (pc_o !== 32'h300 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h500) begin n_bad++; $display("FAIL stall_train got=%h/%b/%h exp=300/1/500", pc_o, pred_taken_o, pred_target_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h500) begin n_bad++; $display("FAIL stall_release got=%h exp=500", pc_o); end
    endtask

    task automatic test_wrap;
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'hFFFF_FFFF); tick;
        n_cmp++; if (pc_o !== 32'hFFFF_FFFC || pred_target_o !== 32'h0) begin n_bad++; $display("FAIL wrap_top got=%h/%h exp=fffffffc/0", pc_o, pred_target_o); end
        tick;
        n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL wrap_zero got=%h exp=0", pc_o); end
        n_cmp++; if (perf_branch_o !== exp_br || perf_mispred_o !== exp_mp) begin n_bad++; $display("FAIL perf_b got=%0d/%0d exp=%0d/%0d", perf_branch_o, perf_mispred_o, exp_br, exp_mp); end
    endtask

    task automatic test_reset_mid;
        rst_i = 1;
        drive_ex(1, 1, 1, 32'h0, 32'h0, 32'h600);
        #1;
        n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_flush got=%b exp=0", flush_o); end
        tick;
        rst_i = 0; exp_br = 0; exp_mp = 0;
        n_cmp++; if (pc_o !== RPC || perf_branch_o !== 0 || perf_mispred_o !== 0) begin n_bad++; $display("FAIL rst_mid_state got=%h/%0d/%0d exp=%h/0/0", pc_o, perf_branch_o, perf_mispred_o, RPC); end
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h208); tick;
        n_cmp++; if (pc_o !== 32'h208 || pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_inv208 got=%h/%b exp=208/0", pc_o, pred_taken_o); end
        drive_ex(0, 0, 1, 32'h0, 32'h0, 32'h300); tick;
        n_cmp++; if (pc_o !== 32'h300 || pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL rst_mid_inv300 got=%h/%b exp=300/0", pc_o, pred_taken_o); end
    endtask

    initial begin
        ex_valid_i = 0; ex_is_branch_i = 0; ex_taken_i = 0; ex_mispredict_i = 0;
        test_reset;
        test_taken_redirect;
        test_ignored_mispredict;
        test_counter;
        test_alias;
        test_stall_redirect;
        test_wrap;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
